alu_serial_arbiter: RTL and testbench

- Shares one serial-interface ALU (sin/sout, 11-bit frames) between N_REQ parallel requesters.
- Arbitrates round-robin and latches the winner's A, B and op.
- Serializes the 9-frame command packet with its computed CRC4 onto sin, then deserializes the ALU's sout response.
- Returns C and the status byte to the granted requester. Sits between on-chip masters and the alu core.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_frame_shifter.sv | 76 +++++++
 rtl/alu_serial_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_alu_serial_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the serial ALU front end: frame layout,
// arbiter state encoding and the CRC4 used on command packets.
package alu_pkg;

    localparam logic DATA_TYPE      = 1'b0;
    localparam logic CMD_TYPE       = 1'b1;
    localparam int   FRAME_BITS     = 11;
    localparam int   TX_FRAMES      = 9;
    localparam int   RX_DATA_FRAMES = 4;

    typedef enum logic [2:0] {
        IDLE,
        TX,
        RX_WAIT,
        RX,
        RESP
    } arb_state_t;

    // CRC4, polynomial x^4+x+1, data consumed MSB first.
    function automatic logic [3:0] crc4_calc(input logic [67:0] data, input logic [3:0] init);
        logic [3:0] crc;
        logic       fb;
        crc = init;
        for (int i = 67; i >= 0; i--) begin
            fb  = crc[3] ^ data[i];
            crc = {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return crc;
    endfunction

endpackage

// File: rtl/alu_frame_shifter.sv
// 11-bit frame serializer and deserializer: start(0), type, d[7:0], stop(1).
// The stop-bit strobes let the owner chain frames back to back.
module alu_frame_shifter
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_load,
    input  logic       tx_type,
    input  logic [7:0] tx_payload,
    output logic       tx_bit,
    output logic       tx_frame_done,
    input  logic       rx_start,
    input  logic       rx_bit,
    output logic       rx_frame_done,
    output logic       rx_stop_ok,
    output logic       rx_type,
    output logic [7:0] rx_payload
);

    localparam int CW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] tx_shift_reg;
    logic [CW-1:0]         tx_cnt_reg;
    logic                  tx_busy_reg;
    logic [8:0]            rx_shift_reg;
    logic [CW-1:0]         rx_cnt_reg;
    logic                  rx_busy_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_reg <= '1;
            tx_cnt_reg   <= '0;
            tx_busy_reg  <= 1'b0;
        end else if (tx_load) begin
            tx_shift_reg <= {1'b0, tx_type, tx_payload, 1'b1};
            tx_cnt_reg   <= '0;
            tx_busy_reg  <= 1'b1;
        end else if (tx_busy_reg) begin
            tx_shift_reg <= {tx_shift_reg[FRAME_BITS-2:0], 1'b1};
            tx_cnt_reg   <= tx_cnt_reg + CW'(1);
            if (tx_cnt_reg == LAST_BIT) begin
                tx_busy_reg <= 1'b0;
            end
        end
    end

    assign tx_bit        = tx_busy_reg ? tx_shift_reg[FRAME_BITS-1] : 1'b1;
    assign tx_frame_done = tx_busy_reg && (tx_cnt_reg == LAST_BIT);

    // The start bit is consumed by whoever raises rx_start, so counting begins at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift_reg <= '0;
            rx_cnt_reg   <= '0;
            rx_busy_reg  <= 1'b0;
        end else if (rx_start) begin
            rx_cnt_reg  <= CW'(1);
            rx_busy_reg <= 1'b1;
        end else if (rx_busy_reg) begin
            rx_cnt_reg <= rx_cnt_reg + CW'(1);
            if (rx_cnt_reg == LAST_BIT) begin
                rx_busy_reg <= 1'b0;
            end else begin
                rx_shift_reg <= {rx_shift_reg[7:0], rx_bit};
            end
        end
    end

    assign rx_frame_done = rx_busy_reg && (rx_cnt_reg == LAST_BIT);
    assign rx_stop_ok    = rx_bit;
    assign rx_type       = rx_shift_reg[8];
    assign rx_payload    = rx_shift_reg[7:0];

endmodule

// File: rtl/alu_serial_arbiter.sv
// Round-robin front end sharing one serial ALU between N_REQ requesters:
// sends a 9-frame command packet on sin and collects the reply from sout.
module alu_serial_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*32-1:0]   req_a,
    input  logic [N_REQ*32-1:0]   req_b,
    input  logic [N_REQ*3-1:0]    req_op,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [31:0]           rsp_c,
    output logic [7:0]            rsp_ctl,
    output logic                  rsp_timeout,
    output logic                  sin,
    input  logic                  sout
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t      state_reg, state_next;
    logic [IW-1:0]   rr_ptr_reg, gnt_reg;
    logic [31:0]     a_reg, b_reg;
    logic [2:0]      op_reg;
    logic [3:0]      crc_reg;
    logic [3:0]      tx_idx_reg;
    logic [2:0]      rx_idx_reg;
    logic [TW-1:0]   to_cnt_reg;
    logic [31:0]     rsp_c_reg;
    logic [7:0]      rsp_ctl_reg;
    logic            rsp_timeout_reg;

    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    int              grant_cand;
    logic [31:0]     sel_a, sel_b;
    logic [2:0]      sel_op;
    logic [3:0]      sel_crc;
    logic [3:0]      tx_next_idx;
    logic            tx_load, tx_type, tx_bit, tx_frame_done;
    logic [7:0]      tx_payload;
    logic            rx_start, rx_frame_done, rx_stop_ok, rx_type, rx_final;
    logic [7:0]      rx_payload;
    logic            grant_fire, resp_active, wait_expired;

    function automatic logic [7:0] tx_byte(input logic [3:0] n, input logic [31:0] a,
                                           input logic [31:0] b, input logic [2:0] op,
                                           input logic [3:0] crc);
        logic [63:0] word;
        word = {b, a};
        if (n < 4'(TX_FRAMES - 1)) begin
            return word[63 - 8*int'(n) -: 8];
        end
        return {1'b0, op, crc};
    endfunction

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            grant_cand = int'(rr_ptr_reg) + k;
            if (grant_cand >= N_REQ) begin
                grant_cand = grant_cand - N_REQ;
            end
            if (!grant_found && req_valid[grant_cand]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(grant_cand);
            end
        end
    end

    assign sel_a   = req_a[32*grant_idx +: 32];
    assign sel_b   = req_b[32*grant_idx +: 32];
    assign sel_op  = req_op[3*grant_idx +: 3];
    assign sel_crc = crc4_calc({sel_b, sel_a, 1'b1, sel_op}, 4'h0);

    // Frame 0 is loaded on the grant edge straight from the requester's inputs.
    assign tx_next_idx = (state_reg == IDLE) ? 4'd0 : tx_idx_reg + 4'd1;
    assign tx_payload  = (state_reg == IDLE) ? tx_byte(4'd0, sel_a, sel_b, sel_op, sel_crc)
                                             : tx_byte(tx_next_idx, a_reg, b_reg, op_reg, crc_reg);
    assign tx_type     = (tx_next_idx == 4'(TX_FRAMES - 1)) ? CMD_TYPE : DATA_TYPE;

    assign rx_final     = ((rx_idx_reg == 3'd0) && (rx_type == CMD_TYPE)) ||
                          (rx_idx_reg == 3'(RX_DATA_FRAMES));
    assign wait_expired = sout && (to_cnt_reg == TW'(TIMEOUT - 1));

    alu_frame_shifter u_shifter (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_load       (tx_load),
        .tx_type       (tx_type),
        .tx_payload    (tx_payload),
        .tx_bit        (tx_bit),
        .tx_frame_done (tx_frame_done),
        .rx_start      (rx_start),
        .rx_bit        (sout),
        .rx_frame_done (rx_frame_done),
        .rx_stop_ok    (rx_stop_ok),
        .rx_type       (rx_type),
        .rx_payload    (rx_payload)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_found) state_next = TX;
            TX:      if (tx_frame_done && tx_idx_reg == 4'(TX_FRAMES - 1)) state_next = RX_WAIT;
            RX_WAIT: if (!sout) state_next = RX;
                     else if (wait_expired) state_next = RESP;
            RX:      if (rx_frame_done) state_next = (!rx_stop_ok || rx_final) ? RESP : RX_WAIT;
            RESP:    if (rsp_ready[gnt_reg]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_fire  = (state_reg == IDLE) && grant_found;
        resp_active = (state_reg == RESP);
        tx_load     = grant_fire ||
                      ((state_reg == TX) && tx_frame_done && tx_idx_reg != 4'(TX_FRAMES - 1));
        rx_start    = (state_reg == RX_WAIT) && !sout;
        sin         = (state_reg == TX) ? tx_bit : 1'b1;
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
        assign req_ready[gi] = grant_fire && (grant_idx == IW'(gi));
        assign rsp_valid[gi] = resp_active && (gnt_reg == IW'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg      <= '0;
            gnt_reg         <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            op_reg          <= '0;
            crc_reg         <= '0;
            tx_idx_reg      <= '0;
            rx_idx_reg      <= '0;
            to_cnt_reg      <= '0;
            rsp_c_reg       <= '0;
            rsp_ctl_reg     <= '0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            to_cnt_reg <= (state_reg == RX_WAIT) ? to_cnt_reg + TW'(1) : '0;
            case (state_reg)
                IDLE: if (grant_found) begin
                    a_reg           <= sel_a;
                    b_reg           <= sel_b;
                    op_reg          <= sel_op;
                    crc_reg         <= sel_crc;
                    gnt_reg         <= grant_idx;
                    rr_ptr_reg      <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);
                    tx_idx_reg      <= '0;
                    rx_idx_reg      <= '0;
                    rsp_c_reg       <= '0;
                    rsp_ctl_reg     <= '0;
                    rsp_timeout_reg <= 1'b0;
                end
                TX: if (tx_frame_done) tx_idx_reg <= tx_idx_reg + 4'd1;
                RX_WAIT: if (wait_expired) begin
                    rsp_timeout_reg <= 1'b1;
                    rsp_c_reg       <= '0;
                    rsp_ctl_reg     <= '0;
                end
                RX: if (rx_frame_done) begin
                    if (!rx_stop_ok) begin
                        rsp_timeout_reg <= 1'b1;
                        rsp_c_reg       <= '0;
                        rsp_ctl_reg     <= '0;
                    end else if (rx_final) begin
                        rsp_ctl_reg <= rx_payload;
                    end else begin
                        rsp_c_reg  <= {rsp_c_reg[23:0], rx_payload};
                        rx_idx_reg <= rx_idx_reg + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_c       = rsp_c_reg;
    assign rsp_ctl     = rsp_ctl_reg;
    assign rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_alu_serial_arbiter.sv
// Directed bench: a behavioural ALU on sin/sout, a vector table of single
// operations, then hand sequences for arbitration, back-pressure and reset.
module tb_alu_serial_arbiter;

    localparam int N_REQ   = 2;
    localparam int TIMEOUT = 16;

    logic                clk;
    logic                rst_n;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*32-1:0] req_a;
    logic [N_REQ*32-1:0] req_b;
    logic [N_REQ*3-1:0]  req_op;
    logic [N_REQ-1:0]    rsp_valid;
    logic [N_REQ-1:0]    rsp_ready;
    logic [31:0]         rsp_c;
    logic [7:0]          rsp_ctl;
    logic                rsp_timeout;
    logic                sin;
    logic                sout;

    int passed = 0;
    int total  = 0;
    int spurious = 0;
    bit tb_busy = 1'b0;

    alu_serial_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_c       (rsp_c),
        .rsp_ctl     (rsp_ctl),
        .rsp_timeout (rsp_timeout),
        .sin         (sin),
        .sout        (sout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Any accept pulse while an operation is outstanding is a protocol breach.
    always @(negedge clk) begin
        if (tb_busy && req_ready != '0) spurious++;
    end

    typedef struct {
        int          r;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        int          mode;   // 0 data reply, 1 error frame, 2 silent
        logic [31:0] rc;
        logic [7:0]  rctl;
        logic [31:0] ec;
        logic [7:0]  ectl;
        logic        eto;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Remainder of (data * x^4) divided by x^4+x+1.
    function automatic logic [3:0] crc_ref(input logic [67:0] d);
        logic [71:0] v;
        v = {d, 4'h0};
        for (int i = 71; i >= 4; i--) begin
            if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
        end
        return v[3:0];
    endfunction

    function automatic logic [98:0] build_pkt(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        logic [98:0] p;
        logic [63:0] w;
        logic [7:0]  by;
        logic        ty;
        w = {b, a};
        for (int k = 0; k < 9; k++) begin
            if (k < 8) begin
                by = w[63 - 8*k -: 8];
                ty = 1'b0;
            end else begin
                by = {1'b0, op, crc_ref({b, a, 1'b1, op})};
                ty = 1'b1;
            end
            p[98 - 11*k -: 11] = {1'b0, ty, by, 1'b1};
        end
        return p;
    endfunction

    task automatic send_frame(input logic ty, input logic [7:0] d);
        logic [10:0] f;
        f = {1'b0, ty, d, 1'b1};
        for (int i = 10; i >= 0; i--) begin
            sout = f[i];
            @(posedge clk); #1;
        end
        sout = 1'b1;
    endtask

    task automatic serve(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input int mode, input logic [31:0] rc,
                         input logic [7:0] rctl, input logic [31:0] ec, input logic [7:0] ectl,
                         input logic eto, input int hold, input bit keep);
        logic [98:0] pkt;
        logic [31:0] c0;
        logic [7:0]  ctl0;
        int          n;
        int          bad;
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        req_op[3*r +: 3]  = op;
        req_valid[r]      = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 300);
        check($sformatf("grant_r%0d", r), 128'(req_ready), 128'(1 << r));
        @(posedge clk); #1;
        if (!keep) req_valid[r] = 1'b0;
        tb_busy = 1'b1;
        for (int i = 0; i < 99; i++) begin
            @(negedge clk);
            pkt[98 - i] = sin;
        end
        check("tx_packet", 128'(pkt), 128'(build_pkt(a, b, op)));
        @(posedge clk); #1;
        if (mode == 2) begin
            n = 0;
            while (n < 200) begin
                @(negedge clk);
                if (rsp_valid != '0) break;
                n++;
            end
            check("timeout_cycles", 128'(n), 128'(TIMEOUT));
        end else begin
            repeat (3) begin
                @(posedge clk); #1;
            end
            check("no_early_rsp", 128'(rsp_valid), 128'(0));
            if (mode == 0) begin
                send_frame(1'b0, rc[31:24]);
                send_frame(1'b0, rc[23:16]);
                send_frame(1'b0, rc[15:8]);
                send_frame(1'b0, rc[7:0]);
                send_frame(1'b1, rctl);
            end else begin
                send_frame(1'b1, rctl);
            end
            @(negedge clk);
        end
        check("rsp_valid_route", 128'(rsp_valid), 128'(1 << r));
        check("rsp_c", 128'(rsp_c), 128'(ec));
        check("rsp_ctl", 128'(rsp_ctl), 128'(ectl));
        check("rsp_timeout", 128'(rsp_timeout), 128'(eto));
        c0   = rsp_c;
        ctl0 = rsp_ctl;
        bad  = 0;
        repeat (hold) begin
            @(negedge clk);
            if (rsp_c !== c0 || rsp_ctl !== ctl0 || rsp_valid !== N_REQ'(1 << r)) bad++;
        end
        if (hold > 0) check("hold_stable", 128'(bad), 128'(0));
        @(posedge clk); #1;
        rsp_ready[r] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[r] = 1'b0;
        tb_busy = 1'b0;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = '0;
        sout      = 1'b1;

        tbl[0] = '{0, 32'h00000001, 32'h00000002, 3'b000, 0, 32'h00000003, 8'h00, 32'h00000003, 8'h00, 1'b0};
        tbl[1] = '{1, 32'hDEADBEEF, 32'h12345678, 3'b101, 1, 32'h0, 8'hA5, 32'h0, 8'hA5, 1'b0};
        tbl[2] = '{0, 32'hFFFFFFFF, 32'h80000001, 3'b111, 2, 32'h0, 8'h00, 32'h0, 8'h00, 1'b1};
        tbl[3] = '{1, 32'h00000007, 32'h00000009, 3'b010, 0, 32'hCAFEF00D, 8'h81, 32'hCAFEF00D, 8'h81, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_sin", 128'(sin), 128'(1));
        check("reset_outs", 128'({req_ready, rsp_valid, rsp_c, rsp_ctl, rsp_timeout}), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            serve(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].mode, tbl[i].rc, tbl[i].rctl,
                  tbl[i].ec, tbl[i].ectl, tbl[i].eto, 0, 1'b0);
        end

        // Both requesters held valid: grants must alternate 0,1,0,1.
        req_a = {32'h00000010, 32'h00000020};
        req_b = {32'h00000030, 32'h00000040};
        req_op = {3'b011, 3'b001};
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                serve(0, 32'h00000020, 32'h00000040, 3'b001, 0, 32'h11110000 + 32'(i), 8'h10,
                      32'h11110000 + 32'(i), 8'h10, 1'b0, 0, 1'b1);
            else
                serve(1, 32'h00000010, 32'h00000030, 3'b011, 0, 32'h22220000 + 32'(i), 8'h20,
                      32'h22220000 + 32'(i), 8'h20, 1'b0, 0, 1'b1);
        end
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;

        // Back-pressure: requester 1 waits while requester 0 sits on its response.
        req_a[63:32] = 32'h0000ABCD;
        req_b[63:32] = 32'h00001234;
        req_op[5:3]  = 3'b110;
        req_valid[1] = 1'b1;
        serve(0, 32'h01020304, 32'h05060708, 3'b100, 0, 32'h89ABCDEF, 8'h42,
              32'h89ABCDEF, 8'h42, 1'b0, 20, 1'b0);
        serve(1, 32'h0000ABCD, 32'h00001234, 3'b110, 1, 32'h0, 8'h5A, 32'h0, 8'h5A, 1'b0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Reset during frame 5 (A[31:24]) of TX.
        req_a[31:0] = 32'h77665544;
        req_b[31:0] = 32'h33221100;
        req_op[2:0] = 3'b001;
        req_valid   = 2'b01;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 300);
        check("rst_grant", 128'(req_ready), 128'(1));
        @(posedge clk); #1;
        req_valid = '0;
        repeat (44) @(negedge clk);
        @(negedge clk);
        check("f5_start_bit", 128'(sin), 128'(0));
        #2 rst_n = 1'b0;
        #1;
        check("rst_sin_high", 128'(sin), 128'(1));
        check("rst_outs", 128'({req_ready, rsp_valid, rsp_c, rsp_ctl, rsp_timeout}), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        req_a[63:32] = 32'h0BADF00D;
        req_b[63:32] = 32'h00C0FFEE;
        req_op[5:3]  = 3'b010;
        req_valid    = 2'b11;
        serve(0, 32'h13572468, 32'h24681357, 3'b011, 0, 32'h0F0F0F0F, 8'h01,
              32'h0F0F0F0F, 8'h01, 1'b0, 0, 1'b1);
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;

        check("no_grant_while_busy", 128'(spurious), 128'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
